// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared cell codes, board size and {y,x} address helpers
package minesweeper_pkg;

    localparam int BOARD_DIM = 16;

    localparam logic [3:0] CELL_BOOM   = 4'hD;
    localparam logic [3:0] CELL_FLAG   = 4'hE;
    localparam logic [3:0] CELL_HIDDEN = 4'hF;

    typedef logic [7:0] cell_addr_t;

    function automatic cell_addr_t pack_addr(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

    function automatic logic [3:0] addr_x(input cell_addr_t a);
        return a[3:0];
    endfunction

    function automatic logic [3:0] addr_y(input cell_addr_t a);
        return a[7:4];
    endfunction

endpackage

// File: rtl/addr_lifo.sv
// rtl/addr_lifo.sv - LIFO of pending cell addresses; pushes into a full stack are dropped
import minesweeper_pkg::*;

module addr_lifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  cell_addr_t din,
    output cell_addr_t top,
    output logic       empty,
    output logic       full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    cell_addr_t    r_mem [DEPTH];
    logic [PW:0]   r_count;
    logic [PW-1:0] w_top_idx;

    assign w_top_idx = r_count[PW-1:0] - 1'b1;
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_count[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + 1'b1;
        end else if (pop && !empty) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/reveal_sequencer.sv
// rtl/reveal_sequencer.sv - flood-fill cell reveal over a shared game-memory port
import minesweeper_pkg::*;

module reveal_sequencer #(
    parameter int STACK_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] start_x,
    input  logic [3:0] start_y,
    output logic       busy,
    output logic       done,
    output logic       gm_req,
    input  logic       gm_gnt,
    output logic       gm_we,
    output logic [7:0] gm_addr,
    output logic [3:0] gm_wdata,
    input  logic [3:0] gm_rdata,
    output logic [7:0] nb_addr,
    input  logic [3:0] nb_cnt,
    input  logic       nb_mine,
    output logic       hit_mine,
    output logic       overflow,
    output logic [7:0] revealed
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_LOOK = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_PUSH = 3'd6;
    localparam logic [2:0] S_FIN  = 3'd7;

    logic [2:0] r_state;
    cell_addr_t r_cell;
    logic [3:0] r_wdata;
    logic [2:0] r_dir;
    logic [7:0] r_revealed;
    logic       r_hit;
    logic       r_ovf;

    logic [4:0] w_dx, w_dy, w_nx, w_ny;
    logic       w_nb_valid;
    cell_addr_t w_nb_addr;
    logic       w_push, w_pop, w_flush, w_empty, w_full;
    cell_addr_t w_din, w_top;

    // Offsets are 5-bit two's complement; bit 4 of the sum flags a step off the board.
    always_comb begin
        w_dx = 5'd0;
        w_dy = 5'd0;
        case (r_dir)
            3'd0: w_dy = 5'h1F;
            3'd1: begin w_dx = 5'd1;  w_dy = 5'h1F; end
            3'd2: w_dx = 5'd1;
            3'd3: begin w_dx = 5'd1;  w_dy = 5'd1;  end
            3'd4: w_dy = 5'd1;
            3'd5: begin w_dx = 5'h1F; w_dy = 5'd1;  end
            3'd6: w_dx = 5'h1F;
            default: begin w_dx = 5'h1F; w_dy = 5'h1F; end
        endcase
    end

    assign w_nx       = {1'b0, addr_x(r_cell)} + w_dx;
    assign w_ny       = {1'b0, addr_y(r_cell)} + w_dy;
    assign w_nb_valid = !w_nx[4] && !w_ny[4];
    assign w_nb_addr  = pack_addr(w_nx[3:0], w_ny[3:0]);

    assign w_push  = ((r_state == S_IDLE) && start) || ((r_state == S_PUSH) && w_nb_valid);
    assign w_din   = (r_state == S_IDLE) ? pack_addr(start_x, start_y) : w_nb_addr;
    assign w_pop   = (r_state == S_POP) && !w_empty;
    assign w_flush = (r_state == S_WR) && gm_gnt && (r_wdata == CELL_BOOM);

    addr_lifo #(.DEPTH(STACK_DEPTH)) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_din),
        .top   (w_top),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cell     <= '0;
            r_wdata    <= '0;
            r_dir      <= '0;
            r_revealed <= '0;
            r_hit      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_revealed <= '0;
                        r_hit      <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_state    <= S_POP;
                    end
                end
                S_POP: begin
                    if (w_empty) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cell  <= w_top;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (gm_gnt) r_state <= S_CHK;
                end
                S_CHK: begin
                    r_state <= (gm_rdata == CELL_HIDDEN) ? S_LOOK : S_POP;
                end
                S_LOOK: begin
                    r_wdata <= nb_mine ? CELL_BOOM : nb_cnt;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (gm_gnt) begin
                        if (r_wdata == CELL_BOOM) begin
                            r_hit   <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            if (r_revealed != 8'hFF) r_revealed <= r_revealed + 8'd1;
                            r_dir   <= '0;
                            r_state <= (r_wdata == 4'd0) ? S_PUSH : S_POP;
                        end
                    end
                end
                S_PUSH: begin
                    if (w_nb_valid && w_full) r_ovf <= 1'b1;
                    r_dir <= r_dir + 3'd1;
                    if (r_dir == 3'd7) r_state <= S_POP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done     = (r_state == S_FIN);
    assign gm_req   = (r_state == S_RD) || (r_state == S_WR);
    assign gm_we    = (r_state == S_WR);
    assign gm_addr  = r_cell;
    assign gm_wdata = r_wdata;
    assign nb_addr  = r_cell;
    assign hit_mine = r_hit;
    assign overflow = r_ovf;
    assign revealed = r_revealed;

endmodule
